// File: rtl/div_pkg.sv
// Shared types and constants for the iterative radix-2 divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int XLEN       = 64;
    localparam int WORD_W     = 32;
    localparam int DIV_ITER_X = 64;
    localparam int DIV_ITER_W = 32;

    // RISC-V defines x/0 as a quotient of all ones.
    localparam logic [XLEN-1:0] DIV0_Q = '1;

endpackage

// File: rtl/div_opprep.sv
// Operand conditioning for div_iter: word/sign extension, magnitudes,
// divide-by-zero and signed-overflow detection and the optional
// early-exit compare (enabled by DIV_EARLY_EXIT_EN).
module div_opprep
    import div_pkg::*;
#(
    parameter int XLEN = div_pkg::XLEN
) (
    input  logic            i_signed,
    input  logic            i_word,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_a_mag,
    output logic [XLEN-1:0] o_b_mag,
    output logic            o_a_neg,
    output logic            o_b_neg,
    output logic            o_div0,
    output logic            o_ovf,
    output logic            o_early
);

    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_min;

    // Word ops keep the low half, extended according to signedness.
    always_comb begin
        w_a = i_a;
        w_b = i_b;
        if (i_word) begin
            w_a = {{(XLEN-WORD_W){i_signed & i_a[WORD_W-1]}}, i_a[WORD_W-1:0]};
            w_b = {{(XLEN-WORD_W){i_signed & i_b[WORD_W-1]}}, i_b[WORD_W-1:0]};
        end
    end

    assign o_a_neg = i_signed & w_a[XLEN-1];
    assign o_b_neg = i_signed & w_b[XLEN-1];
    assign o_a_mag = o_a_neg ? -w_a : w_a;
    assign o_b_mag = o_b_neg ? -w_b : w_b;

    // Most negative value at the operating width, already sign-extended.
    assign w_min  = i_word ? {{(XLEN-WORD_W+1){1'b1}}, {(WORD_W-1){1'b0}}}
                           : {1'b1, {(XLEN-1){1'b0}}};
    assign o_div0 = (w_b == '0);
    assign o_ovf  = i_signed & (w_a == w_min) & (w_b == '1);

`ifdef DIV_EARLY_EXIT_EN
    assign o_early = ~o_div0 & (o_a_mag < o_b_mag);
`else
    assign o_early = 1'b0;
`endif

endmodule

// File: rtl/div_iter.sv
// Iterative restoring radix-2 divider for RV64M div/rem (XLEN and word forms).
// Holds the request while valid_i stays high; dropping valid_i mid-calc aborts.
// Optional DIV_EARLY_EXIT_EN finishes |a| < |b| at accept time.
module div_iter
    import div_pkg::*;
#(
    parameter int XLEN  = div_pkg::XLEN,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            signed_i,
    input  logic            word_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            data_ok_o,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o
);

    div_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_q, r_r, r_b, r_quot, r_rem;
    logic             r_word, r_q_neg, r_r_neg, r_ok;

    logic [XLEN-1:0]  w_a_mag, w_b_mag, w_q_s, w_r_s, w_q_fin, w_r_fin;
    logic             w_a_neg, w_b_neg, w_div0, w_ovf, w_early, w_ge;
    logic [XLEN:0]    w_rem_sh, w_diff;

    div_opprep #(.XLEN(XLEN)) u_opprep (
        .i_signed (signed_i),
        .i_word   (word_i),
        .i_a      (a_i),
        .i_b      (b_i),
        .o_a_mag  (w_a_mag),
        .o_b_mag  (w_b_mag),
        .o_a_neg  (w_a_neg),
        .o_b_neg  (w_b_neg),
        .o_div0   (w_div0),
        .o_ovf    (w_ovf),
        .o_early  (w_early)
    );

    // One restoring step: shift in the next dividend bit, try subtracting.
    assign w_rem_sh = {r_r, r_q[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_b};
    assign w_ge     = ~w_diff[XLEN];

    // Sign fix-up, then word results are sign-extended from bit 31.
    assign w_q_s   = r_q_neg ? -r_q : r_q;
    assign w_r_s   = r_r_neg ? -r_r : r_r;
    assign w_q_fin = r_word ? {{(XLEN-WORD_W){w_q_s[WORD_W-1]}}, w_q_s[WORD_W-1:0]} : w_q_s;
    assign w_r_fin = r_word ? {{(XLEN-WORD_W){w_r_s[WORD_W-1]}}, w_r_s[WORD_W-1:0]} : w_r_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic: specials skip CALC, valid_i low in CALC aborts.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (valid_i) w_state_nxt = (w_div0 | w_ovf | w_early) ? DONE : CALC;
            CALC:    if (!valid_i)                 w_state_nxt = IDLE;
                     else if (r_cnt == CNT_W'(1))  w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: load at accept, iterate in CALC, publish results from DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_b     <= '0;
            r_word  <= 1'b0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_ok    <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
        end else begin
            r_ok <= 1'b0;
            unique case (r_state)
                IDLE: if (valid_i) begin
                    r_word  <= word_i;
                    r_b     <= w_b_mag;
                    r_q_neg <= w_a_neg ^ w_b_neg;
                    r_r_neg <= w_a_neg;
                    r_cnt   <= word_i ? CNT_W'(DIV_ITER_W) : CNT_W'(XLEN);
                    // Word dividends are parked in the top half so the
                    // MSB-first shift starts at bit 31.
                    r_q     <= word_i ? (w_a_mag << WORD_W) : w_a_mag;
                    r_r     <= '0;
                    if (w_div0) begin
                        r_q     <= DIV0_Q;
                        r_q_neg <= 1'b0;
                        r_r     <= w_a_mag;
                    end else if (w_ovf) begin
                        // Both operands negative, so the unnegated magnitude
                        // reproduces the most negative dividend.
                        r_q <= w_a_mag;
                        r_r <= '0;
                    end else if (w_early) begin
                        r_q <= '0;
                        r_r <= w_a_mag;
                    end
                end
                CALC: if (valid_i) begin
                    r_cnt <= r_cnt - 1'b1;
                    r_q   <= {r_q[XLEN-2:0], w_ge};
                    r_r   <= w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
                end
                DONE: begin
                    r_ok   <= 1'b1;
                    r_quot <= w_q_fin;
                    r_rem  <= w_r_fin;
                end
                default: ;
            endcase
        end
    end

    assign data_ok_o = r_ok;
    assign quot_o    = r_quot;
    assign rem_o     = r_rem;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: vector table plus abort, reset and
// back-to-back sequences. Honours DIV_EARLY_EXIT_EN for expected latency.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst, signed_i, word_i, valid_i;
    logic [63:0] a_i, b_i;
    logic        data_ok_o;
    logic [63:0] quot_o, rem_o;

    int n_chk = 0;
    int n_err = 0;

`ifdef DIV_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef struct {
        logic        s;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
        bit          ee;
    } vec_t;

    vec_t vecs[15];

    div_iter #(.XLEN(64), .CNT_W(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .signed_i  (signed_i),
        .word_i    (word_i),
        .valid_i   (valid_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .data_ok_o (data_ok_o),
        .quot_o    (quot_o),
        .rem_o     (rem_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Caller is #1 after an edge. Returns edges from accept to data_ok (-1 on timeout).
    task automatic do_op(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b,
                         output int lat, output logic [63:0] q, output logic [63:0] r);
        signed_i = s; word_i = w; a_i = a; b_i = b; valid_i = 1'b1;
        @(posedge clk); #1;
        a_i = ~a; b_i = ~b;  // must be ignored after accept
        lat = -1; q = 'x; r = 'x;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (data_ok_o) begin
                lat = k; q = quot_o; r = rem_o;
                break;
            end
        end
        valid_i = 1'b0;
    endtask

    // Count data_ok pulses over n edges.
    task automatic watch(input int n, output int seen);
        seen = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (data_ok_o) seen++;
        end
    endtask

    initial begin
        int          lat, seen, elat;
        logic [63:0] q, r;

        vecs[0]  = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd3, 64'h0000_0000_2AAA_AAAA, 64'd2, 33, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd0, 1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 65, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 64'h0000_0001_8000_0001, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000, 65, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 64'd3, 64'd10, 64'd0, 64'd3, 65, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b1};

        // Reset state
        rst = 1'b1; valid_i = 1'b0; signed_i = 1'b0; word_i = 1'b0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ok", 64'(data_ok_o), 64'd0);
        chk("rst_quot", quot_o, 64'd0);
        chk("rst_rem", rem_o, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Vector table
        foreach (vecs[i]) begin
            elat = (EE && vecs[i].ee) ? 1 : vecs[i].lat;
            do_op(vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].b, lat, q, r);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(elat));
            chk($sformatf("v%0d_quot", i), q, vecs[i].q);
            chk($sformatf("v%0d_rem", i), r, vecs[i].r);
            @(posedge clk); #1;
            chk($sformatf("v%0d_pulse", i), 64'(data_ok_o), 64'd0);
            chk($sformatf("v%0d_hold", i), quot_o, vecs[i].q);
        end
        // Last result on the outputs is vecs[14].

        // Abort: drop valid_i in CALC cycle 10
        signed_i = 1'b0; word_i = 1'b0; a_i = 64'd100; b_i = 64'd7; valid_i = 1'b1;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        valid_i = 1'b0;
        watch(80, seen);
        chk("abort_no_ok", 64'(seen), 64'd0);
        chk("abort_quot", quot_o, vecs[14].q);
        chk("abort_rem", rem_o, vecs[14].r);
        do_op(1'b0, 1'b0, 64'd100, 64'd7, lat, q, r);
        chk("abort_re_lat", 64'(lat), 64'd65);
        chk("abort_re_quot", q, 64'd14);
        chk("abort_re_rem", r, 64'd2);

        // Reset mid-CALC
        @(posedge clk); #1;
        a_i = 64'd100; b_i = 64'd7; valid_i = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; valid_i = 1'b0;
        watch(80, seen);
        chk("rstmid_no_ok", 64'(seen), 64'd0);
        chk("rstmid_quot", quot_o, 64'd0);
        chk("rstmid_rem", rem_o, 64'd0);
        do_op(1'b0, 1'b0, 64'd100, 64'd7, lat, q, r);
        chk("rstmid_re_lat", 64'(lat), 64'd65);
        chk("rstmid_re_quot", q, 64'd14);
        chk("rstmid_re_rem", r, 64'd2);

        // Back-to-back: second request raised while data_ok is high
        @(posedge clk); #1;
        do_op(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat, q, r);
        chk("b2b_first_lat", 64'(lat), 64'd65);
        signed_i = 1'b0; word_i = 1'b0; a_i = 64'd9; b_i = 64'd4; valid_i = 1'b1;
        @(posedge clk); #1;
        a_i = 64'd1; b_i = 64'd1;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k == 30) begin
                chk("b2b_hold_quot", quot_o, 64'hFFFF_FFFF_FFFF_FFFD);
                chk("b2b_hold_rem", rem_o, 64'hFFFF_FFFF_FFFF_FFFF);
            end
            if (data_ok_o) begin
                lat = k; q = quot_o; r = rem_o;
                break;
            end
        end
        valid_i = 1'b0;
        chk("b2b_lat", 64'(lat), 64'd65);
        chk("b2b_quot", q, 64'd2);
        chk("b2b_rem", r, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
